// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC register and decode.
// Tracks the one synchronous instruction-memory read in flight and buffers
// completed fetches as {pc, pc+1, instr} in a small FIFO that decode pops.
// Wrong-path work is dropped on flush. Occupancy is fed back as fetch_stall.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] im_instr,
  input  logic               flush,
  input  logic               id_stall,
  output logic               fetch_stall,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_4,
  output logic [INSTR_W-1:0] id_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_pend_v;
  logic [ADDR_W-1:0]  r_pend_pc;

  logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
  logic [ADDR_W-1:0]  r_pc4_mem   [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];

  logic [CNT_W:0]     w_occ;
  logic               w_issue;
  logic               w_enq;
  logic               w_deq;

  // The in-flight read counts as occupied, so an arriving read always has a slot.
  assign w_occ       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_pend_v};
  assign fetch_stall = (w_occ >= (CNT_W+1)'(DEPTH));

  assign w_issue  = en & ~fetch_stall & ~flush;
  assign w_enq    = r_pend_v & ~flush;
  assign id_valid = (r_count != '0) & ~flush;
  assign w_deq    = id_valid & ~id_stall;

  // Head is read combinationally; no bypass from the entry being written.
  assign id_pc    = r_pc_mem[r_rd_ptr];
  assign id_pc_4  = r_pc4_mem[r_rd_ptr];
  assign id_instr = r_instr_mem[r_rd_ptr];

  // Control state: pending read, pointers and occupancy; flush empties everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_pend_v  <= w_issue;
      r_pend_pc <= pc;
      if (flush) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      end
    end
  end

  // Entry storage: the completed read lands at the write pointer; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_mem[r_wr_ptr]    <= r_pend_pc;
      r_pc4_mem[r_wr_ptr]   <= r_pend_pc + ADDR_W'(1);
      r_instr_mem[r_wr_ptr] <= im_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a PC model and a synchronous IM model
// drive the queue; issued fetches go into a scoreboard and are compared
// against decode-side output as they are popped.
module tb_fetch_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [ADDR_W-1:0]  pc = '0;
  logic [INSTR_W-1:0] im_instr = '0;
  logic               flush = 1'b0;
  logic               id_stall = 1'b0;
  logic               fetch_stall;
  logic               id_valid;
  logic [ADDR_W-1:0]  id_pc;
  logic [ADDR_W-1:0]  id_pc_4;
  logic [INSTR_W-1:0] id_instr;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc(pc), .im_instr(im_instr),
    .flush(flush), .id_stall(id_stall), .fetch_stall(fetch_stall),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_4(id_pc_4), .id_instr(id_instr)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data for pc appears one cycle later.
  always @(posedge clk) im_instr <= 32'h2008_0001 + 32'(pc);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc4;
    logic [INSTR_W-1:0] ins;
  } ent_t;

  ent_t              sb[$];
  int                n_chk = 0;
  int                n_pass = 0;
  bit                prev_issue = 1'b0;
  logic [ADDR_W-1:0] load_pc = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock cycle, entered just after a falling edge with inputs already set.
  task automatic cyc();
    bit   ev;
    bit   st;
    bit   iss;
    ent_t e;
    #1;
    st = (sb.size() >= DEPTH);
    ev = ((sb.size() - int'(prev_issue)) != 0) && !flush;
    chk("fetch_stall", 64'(fetch_stall), 64'(st));
    chk("id_valid", 64'(id_valid), 64'(ev));
    if (ev && !id_stall && sb.size() != 0) begin
      e = sb.pop_front();
      chk("id_pc", 64'(id_pc), 64'(e.pc));
      chk("id_pc_4", 64'(id_pc_4), 64'(e.pc4));
      chk("id_instr", 64'(id_instr), 64'(e.ins));
    end
    if (flush) sb.delete();
    iss = en && !st && !flush;
    if (iss) begin
      e.pc  = pc;
      e.pc4 = pc + ADDR_W'(1);
      e.ins = 32'h2008_0001 + 32'(pc);
      sb.push_back(e);
    end
    prev_issue = iss;
    @(negedge clk);
    if (flush) pc = load_pc;
    else if (iss) pc = pc + ADDR_W'(1);
  endtask

  task automatic drain();
    en = 1'b0;
    id_stall = 1'b0;
    flush = 1'b0;
    repeat (DEPTH + 3) cyc();
  endtask

  initial begin
    // Reset from power-up
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_fetch_stall", 64'(fetch_stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at full rate, then en=0 lets the pending read still land
    en = 1'b1;
    pc = '0;
    repeat (8) cyc();
    drain();

    // Fill with decode stalled, then release
    en = 1'b1;
    id_stall = 1'b1;
    repeat (8) cyc();
    id_stall = 1'b0;
    repeat (6) cyc();
    drain();

    // Flush with three entries queued and one read pending
    en = 1'b1;
    id_stall = 1'b1;
    repeat (4) cyc();
    flush = 1'b1;
    load_pc = 8'h40;
    cyc();
    flush = 1'b0;
    id_stall = 1'b0;
    repeat (6) cyc();
    drain();

    // Address wrap and pointer wrap with random decode stalls
    pc = 8'hFD;
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      id_stall = 1'($urandom_range(0, 1));
      cyc();
    end
    drain();

    // Near-full with simultaneous enqueue and dequeue
    en = 1'b1;
    id_stall = 1'b1;
    repeat (3) cyc();
    id_stall = 1'b0;
    repeat (6) cyc();
    drain();

    // Asynchronous reset while the queue holds entries
    en = 1'b1;
    id_stall = 1'b1;
    repeat (4) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_id_valid", 64'(id_valid), 64'd0);
    chk("arst_fetch_stall", 64'(fetch_stall), 64'd0);
    sb.delete();
    prev_issue = 1'b0;
    @(negedge clk);
    pc = '0;
    rst_n = 1'b1;
    id_stall = 1'b0;
    en = 1'b1;
    repeat (6) cyc();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
